eth_f_avst_rx_pkt_monitor: RTL and testbench
============================================

ETH_F_AVST_RX_PKT_MONITOR -- requirements
Module: eth_f_avst_rx_pkt_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 64, lane width in bits.
REQ-002 SHALL have parameter WORDS, default 1, lanes per beat; beat width BW = WIDTH*WORDS, bytes per beat NB = BW/8.
REQ-003 SHALL have parameter EMPTY_WIDTH, default 6, empty field width; legal empty values are 0..NB-1.
REQ-004 SHALL have parameter MIN_LEN, default 64, minimum legal frame length in bytes.
REQ-005 SHALL have parameter MAX_LEN, default 9600, maximum legal frame length in bytes.
REQ-006 SHALL have parameter CNT_W, default 32, width of statistics counters.
REQ-007 SHALL have port i_clk_rx, input, 1, RX clock; all logic in this domain.
REQ-008 SHALL have port i_arst, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port i_avst_rx_valid, input, 1, tapped AVST valid.
REQ-010 SHALL have port i_avst_rx_ready, input, 1, tapped AVST ready from the downstream sink.
REQ-011 SHALL have port i_avst_rx_sop, input, 1, tapped start of packet.
REQ-012 SHALL have port i_avst_rx_eop, input, 1, tapped end of packet.
REQ-013 SHALL have port i_avst_rx_empty, input, EMPTY_WIDTH, empty bytes; meaningful only with eop.
REQ-014 SHALL have port i_stats_clr, input, 1, synchronous clear of all counters.
REQ-015 SHALL have ports o_pkt_cnt, o_byte_cnt, o_runt_cnt, o_oversize_cnt, o_framing_err_cnt, outputs, CNT_W each, statistics.
REQ-016 SHALL have port o_last_len, output, 16, length of the most recently completed frame in bytes.
REQ-017 SHALL have port o_in_pkt, output, 1, high while a frame is open.

Function
REQ-018 SHALL be a passive tap: drives nothing onto the stream; a beat counts only when i_avst_rx_valid & i_avst_rx_ready ("accepted").
REQ-019 SHALL implement FSM IDLE/IN_PKT; o_in_pkt = (state == IN_PKT).
REQ-020 In IDLE, accepted sop&~eop SHALL load running length = NB and go to IN_PKT.
REQ-021 In IDLE, accepted sop&eop SHALL complete a single-beat frame of length NB - empty and stay IDLE.
REQ-022 In IDLE, accepted beat without sop SHALL increment o_framing_err_cnt and be otherwise ignored (orphan).
REQ-023 In IN_PKT, accepted ~sop&~eop SHALL add NB to running length.
REQ-024 In IN_PKT, accepted ~sop&eop SHALL complete the frame with length = running + NB - empty and go to IDLE.
REQ-025 In IN_PKT, accepted sop SHALL increment o_framing_err_cnt, discard the open frame uncounted, and restart per REQ-020/REQ-021.
REQ-026 Running length SHALL saturate at 16'hFFFF.
REQ-027 On frame completion with length L: o_pkt_cnt +1, o_byte_cnt +L, o_last_len = L; additionally o_runt_cnt +1 if L < MIN_LEN, o_oversize_cnt +1 if L > MAX_LEN.
REQ-028 All counters and o_last_len SHALL update on the clock edge that accepts the eop beat (visible the following cycle), one-cycle latency.
REQ-029 Counters SHALL saturate at all-ones, never wrap; o_byte_cnt saturates rather than overflowing on the add.
REQ-030 i_stats_clr SHALL zero all five counters and o_last_len next cycle; clear wins over a same-cycle increment; FSM and running length are unaffected.
REQ-031 Empty values >= NB SHALL be clamped to NB-1 for length arithmetic.
REQ-032 Beats with valid high and ready low SHALL leave all state unchanged.

Reset
REQ-033 i_arst low SHALL asynchronously force state IDLE, running length 0, all counters 0, o_last_len 0, o_in_pkt 0.
REQ-034 Reset release SHALL be synchronised to i_clk_rx; a frame open at reset assertion is dropped uncounted.

Verification
REQ-035 WIDTH=64: 8 beats, sop on beat 1, eop on beat 8, empty=0 -> o_pkt_cnt=1, o_byte_cnt=64, o_last_len=64, o_runt_cnt=0.
REQ-036 8 beats, eop empty=4 -> o_last_len=60, o_runt_cnt=1; 1203 beats, empty=0 -> o_last_len=9624, o_oversize_cnt=1.
REQ-037 sop, 3 beats, second sop without eop, 8-beat frame -> o_framing_err_cnt=1, o_pkt_cnt=1, o_last_len=64; then orphan beat -> o_framing_err_cnt=2.
REQ-038 valid=1/ready=0 stalls inserted on every beat of a 64-byte frame -> counts identical to REQ-035.
REQ-039 CNT_W=4: 17 frames -> o_pkt_cnt=15 (saturated); i_stats_clr coincident with an eop beat -> all counters 0 next cycle.
REQ-040 i_arst asserted mid-frame (beat 4 of 8), released, then a complete 64-byte frame -> o_pkt_cnt=1, o_framing_err_cnt=0.

Source files
------------

// File: rtl/eth_f_avst_rx_pkt_monitor.sv
// Passive AVST RX tap that tracks frame boundaries and keeps saturating frame statistics.
// Latency: counters, o_last_len and o_in_pkt reflect an accepted beat on the following cycle.
// Backpressure: none exerted; a beat is counted only when valid & ready, and stalled beats leave state unchanged.
//
// Ports:
//   i_clk_rx, i_arst              RX clock; asynchronous active-low reset (release synchronised internally)
//   i_avst_rx_valid/ready         tapped handshake; a beat is accepted when both are high
//   i_avst_rx_sop/eop/empty       tapped framing; empty is used only on the eop beat, clamped to NB-1
//   i_stats_clr                   synchronous clear of counters and o_last_len (FSM untouched)
//   o_pkt_cnt .. o_framing_err_cnt saturating statistics, CNT_W bits each
//   o_last_len                    length in bytes of the most recently completed frame
//   o_in_pkt                      high while a frame is open
module eth_f_avst_rx_pkt_monitor #(
  parameter int WIDTH       = 64,
  parameter int WORDS       = 1,
  parameter int EMPTY_WIDTH = 6,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 9600,
  parameter int CNT_W       = 32
) (
  input  logic                   i_clk_rx,
  input  logic                   i_arst,
  input  logic                   i_avst_rx_valid,
  input  logic                   i_avst_rx_ready,
  input  logic                   i_avst_rx_sop,
  input  logic                   i_avst_rx_eop,
  input  logic [EMPTY_WIDTH-1:0] i_avst_rx_empty,
  input  logic                   i_stats_clr,
  output logic [CNT_W-1:0]       o_pkt_cnt,
  output logic [CNT_W-1:0]       o_byte_cnt,
  output logic [CNT_W-1:0]       o_runt_cnt,
  output logic [CNT_W-1:0]       o_oversize_cnt,
  output logic [CNT_W-1:0]       o_framing_err_cnt,
  output logic [15:0]            o_last_len,
  output logic                   o_in_pkt
);

  localparam int          NB     = (WIDTH * WORDS) / 8;
  localparam logic [31:0] NB_32  = 32'(NB);
  localparam logic [16:0] NB_17  = 17'(NB);
  localparam logic [31:0] MIN_32 = 32'(MIN_LEN);
  localparam logic [31:0] MAX_32 = 32'(MAX_LEN);
  // Adder width for the byte counter: wide enough for either operand plus carry.
  localparam int          AW     = ((CNT_W > 16) ? CNT_W : 16) + 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  function automatic logic [15:0] sat16(input logic [16:0] x);
    return x[16] ? 16'hFFFF : x[15:0];
  endfunction

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] add_sat(input logic [CNT_W-1:0] c, input logic [15:0] l);
    logic [AW-1:0] s;
    s = AW'(c) + AW'(l);
    if (s > AW'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  // Reset synchroniser: assertion is immediate, release takes two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk_rx or negedge i_arst) begin
    if (!i_arst) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_t      state_q, state_d;
  logic [15:0] run_q, run_d;
  logic        acc;
  logic [16:0] empty_cl;
  logic [15:0] single_len, multi_len, run_inc;
  logic        done;
  logic [15:0] done_len;
  logic        ferr;

  assign acc = i_avst_rx_valid & i_avst_rx_ready;

  // Out-of-range empty is clamped so every eop beat contributes at least one byte.
  always_comb begin
    if (32'(i_avst_rx_empty) >= NB_32) empty_cl = NB_17 - 17'd1;
    else                               empty_cl = 17'(i_avst_rx_empty);
  end

  assign single_len = 16'(NB_17 - empty_cl);
  assign multi_len  = sat16({1'b0, run_q} + NB_17 - empty_cl);
  assign run_inc    = sat16({1'b0, run_q} + NB_17);

  always_ff @(posedge i_clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    done     = 1'b0;
    done_len = '0;
    ferr     = 1'b0;
    if (acc) begin
      if (i_avst_rx_sop) begin
        // A sop inside an open frame abandons that frame and starts afresh.
        ferr = (state_q == IN_PKT);
        if (i_avst_rx_eop) begin
          done     = 1'b1;
          done_len = single_len;
          state_d  = IDLE;
          run_d    = '0;
        end else begin
          state_d = IN_PKT;
          run_d   = NB_17[15:0];
        end
      end else if (state_q == IDLE) begin
        ferr = 1'b1;
      end else if (i_avst_rx_eop) begin
        done     = 1'b1;
        done_len = multi_len;
        state_d  = IDLE;
        run_d    = '0;
      end else begin
        run_d = run_inc;
      end
    end
  end

  logic [CNT_W-1:0] pkt_q, byte_q, runt_q, ovs_q, ferr_q;
  logic [15:0]      last_q;

  always_ff @(posedge i_clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q  <= '0;
      byte_q <= '0;
      runt_q <= '0;
      ovs_q  <= '0;
      ferr_q <= '0;
      last_q <= '0;
    end else if (i_stats_clr) begin
      pkt_q  <= '0;
      byte_q <= '0;
      runt_q <= '0;
      ovs_q  <= '0;
      ferr_q <= '0;
      last_q <= '0;
    end else begin
      if (ferr) ferr_q <= inc_sat(ferr_q);
      if (done) begin
        pkt_q  <= inc_sat(pkt_q);
        byte_q <= add_sat(byte_q, done_len);
        last_q <= done_len;
        if (32'(done_len) < MIN_32) runt_q <= inc_sat(runt_q);
        if (32'(done_len) > MAX_32) ovs_q  <= inc_sat(ovs_q);
      end
    end
  end

  assign o_pkt_cnt         = pkt_q;
  assign o_byte_cnt        = byte_q;
  assign o_runt_cnt        = runt_q;
  assign o_oversize_cnt    = ovs_q;
  assign o_framing_err_cnt = ferr_q;
  assign o_last_len        = last_q;
  assign o_in_pkt          = (state_q == IN_PKT);

endmodule

// File: tb/tb_eth_f_avst_rx_pkt_monitor.sv
// Bench for the AVST RX packet monitor: two instances (32-bit and 4-bit counters) share one stimulus stream.
// Expected values come from a frame-level model (beat counting, unbounded totals clipped at compare time).
// Each cycle's expected snapshot is queued by the stimulus and checked by an independent negedge monitor.
module tb_eth_f_avst_rx_pkt_monitor;

  localparam int NB = 8;

  logic       clk   = 1'b0;
  logic       arst  = 1'b1;
  logic       valid = 1'b0;
  logic       ready = 1'b0;
  logic       sop   = 1'b0;
  logic       eop   = 1'b0;
  logic       clr   = 1'b0;
  logic [5:0] empty = '0;

  logic [31:0] pkt, byt, runt, ovs, ferr;
  logic [15:0] last;
  logic        inpkt;
  logic [3:0]  pkt4, byt4, runt4, ovs4, ferr4;
  logic [15:0] last4;
  logic        inpkt4;

  always #5 clk = ~clk;

  eth_f_avst_rx_pkt_monitor u_dut (
    .i_clk_rx(clk), .i_arst(arst),
    .i_avst_rx_valid(valid), .i_avst_rx_ready(ready),
    .i_avst_rx_sop(sop), .i_avst_rx_eop(eop), .i_avst_rx_empty(empty),
    .i_stats_clr(clr),
    .o_pkt_cnt(pkt), .o_byte_cnt(byt), .o_runt_cnt(runt), .o_oversize_cnt(ovs),
    .o_framing_err_cnt(ferr), .o_last_len(last), .o_in_pkt(inpkt)
  );

  eth_f_avst_rx_pkt_monitor #(.CNT_W(4)) u_dut4 (
    .i_clk_rx(clk), .i_arst(arst),
    .i_avst_rx_valid(valid), .i_avst_rx_ready(ready),
    .i_avst_rx_sop(sop), .i_avst_rx_eop(eop), .i_avst_rx_empty(empty),
    .i_stats_clr(clr),
    .o_pkt_cnt(pkt4), .o_byte_cnt(byt4), .o_runt_cnt(runt4), .o_oversize_cnt(ovs4),
    .o_framing_err_cnt(ferr4), .o_last_len(last4), .o_in_pkt(inpkt4)
  );

  // Reference model: frame-level view. Totals are unbounded since the last clear.
  typedef struct {
    longint pkt, byt, runt, ovs, ferr;
    longint last;
    bit     inpkt;
  } exp_t;

  exp_t   q[$];
  bit     m_open;
  int     m_beats;
  longint t_pkt, t_byt, t_runt, t_ovs, t_ferr, m_last;
  int     nvec = 0;
  int     nerr = 0;

  task automatic model_zero();
    m_open = 0; m_beats = 0;
    t_pkt = 0; t_byt = 0; t_runt = 0; t_ovs = 0; t_ferr = 0; m_last = 0;
  endtask

  task automatic complete(input longint len);
    longint l;
    l = (len > 65535) ? 65535 : len;
    t_pkt++;
    t_byt += l;
    if (l < 64)   t_runt++;
    if (l > 9600) t_ovs++;
    m_last = l;
  endtask

  task automatic model(input bit v, r, s, e, input int emp, input bit c);
    int ec;
    ec = (emp >= NB) ? NB - 1 : emp;
    if (v && r) begin
      if (s) begin
        if (m_open) t_ferr++;
        if (e) begin complete(NB - ec); m_open = 0; end
        else   begin m_open = 1; m_beats = 1; end
      end else if (!m_open) begin
        t_ferr++;
      end else begin
        m_beats++;
        if (e) begin complete(longint'(m_beats) * NB - ec); m_open = 0; end
      end
    end
    if (c) begin
      t_pkt = 0; t_byt = 0; t_runt = 0; t_ovs = 0; t_ferr = 0; m_last = 0;
    end
  endtask

  task automatic push();
    exp_t x;
    x.pkt = t_pkt; x.byt = t_byt; x.runt = t_runt; x.ovs = t_ovs; x.ferr = t_ferr;
    x.last = m_last; x.inpkt = m_open;
    q.push_back(x);
  endtask

  // One clock of stimulus; the snapshot pushed is the state expected after the coming edge.
  task automatic cyc(input bit v, r, s, e, input int emp, input bit c);
    valid = v; ready = r; sop = s; eop = e; empty = 6'(emp); clr = c;
    if (arst) model(v, r, s, e, emp & 63, c);
    push();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(63), 0);
  endtask

  task automatic clear();
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  // Frame of nb beats; random stalls (valid & ~ready) before beats, or exactly one per beat when fixed_stall.
  task automatic frame(input int nb, input int emp, input int stall_pct, input bit fixed_stall, input bit clr_eop);
    bit s, e;
    for (int b = 0; b < nb; b++) begin
      s = (b == 0);
      e = (b == nb - 1);
      if (fixed_stall) cyc(1, 0, s, e, emp, 0);
      else while ($urandom_range(99) < stall_pct) cyc(1, 0, s, e, emp, 0);
      cyc(1, 1, s, e, e ? emp : $urandom_range(63), e && clr_eop);
    end
  endtask

  // Reset is asserted just after a monitor check so that check still sees pre-reset state.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #1;
    arst = 0;
    valid = 0; ready = 0; sop = 0; eop = 0; clr = 0;
    model_zero();
    for (int i = 0; i < hold; i++) cyc(0, 0, 0, 0, 0, 0);
    arst = 1;
    idle(3);
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("pkt_cnt",         longint'(pkt),   sat(x.pkt, 32));
      chk("byte_cnt",        longint'(byt),   sat(x.byt, 32));
      chk("runt_cnt",        longint'(runt),  sat(x.runt, 32));
      chk("oversize_cnt",    longint'(ovs),   sat(x.ovs, 32));
      chk("framing_err_cnt", longint'(ferr),  sat(x.ferr, 32));
      chk("last_len",        longint'(last),  x.last);
      chk("in_pkt",          longint'(inpkt), longint'(x.inpkt));
      chk("pkt_cnt4",        longint'(pkt4),  sat(x.pkt, 4));
      chk("byte_cnt4",       longint'(byt4),  sat(x.byt, 4));
      chk("runt_cnt4",       longint'(runt4), sat(x.runt, 4));
      chk("oversize_cnt4",   longint'(ovs4),  sat(x.ovs, 4));
      chk("framing_err4",    longint'(ferr4), sat(x.ferr, 4));
      chk("last_len4",       longint'(last4), x.last);
      chk("in_pkt4",         longint'(inpkt4), longint'(x.inpkt));
    end
  end

  initial begin
    int r;
    do_reset(3);

    // 64-byte frame, then 60-byte runt, then 9624-byte oversize frame.
    clear(); frame(8, 0, 0, 0, 0); idle(2);
    clear(); frame(8, 4, 0, 0, 0); idle(1); frame(1203, 0, 0, 0, 0); idle(2);

    // Open frame abandoned by a new sop, then an orphan beat.
    clear();
    cyc(1, 1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0);
    frame(8, 0, 0, 0, 0); idle(1);
    cyc(1, 1, 0, 0, 0, 0); idle(2);

    // A stall on every beat must not change the outcome.
    clear(); frame(8, 0, 0, 1, 0); idle(2);

    // Single-beat frames including out-of-range empty values.
    clear(); frame(1, 0, 0, 0, 0); frame(1, 7, 0, 0, 0); frame(1, 20, 0, 0, 0); frame(2, 63, 0, 0, 0); idle(2);

    // Saturation of the narrow counters, then clear landing on an eop beat.
    clear();
    for (int i = 0; i < 17; i++) frame(8, 0, 0, 0, 0);
    idle(1);
    frame(8, 0, 0, 0, 1); idle(2);

    // Reset in the middle of a frame, then a clean frame.
    clear();
    for (int b = 0; b < 4; b++) cyc(1, 1, b == 0, 0, 0, 0);
    do_reset(2);
    frame(8, 0, 0, 0, 0); idle(2);

    // Random traffic.
    clear();
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(99);
      if (r < 8) begin
        cyc(1, 1, 0, 1'($urandom_range(1)), $urandom_range(63), 0);
      end else if (r < 16) begin
        cyc(1, 1, 1, 0, 0, 0);
        for (int k = 0; k < int'($urandom_range(3)); k++) cyc(1, 1, 0, 0, 0, 0);
      end else if (r < 20) begin
        clear();
      end else begin
        frame($urandom_range(24, 1), $urandom_range(15), 30, 0, ($urandom_range(9) == 0));
      end
      idle($urandom_range(3));
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
